legv8_multicycle_control: RTL and testbench
===========================================

Name: legv8_multicycle_control

Overview:
- Main control FSM for the multicycle LEGv8 datapath.
- Sits directly upstream of the ALU control block: sequences each instruction through fetch/decode/execute/memory/writeback and drives ALUop plus every datapath enable.
- Memory accesses use a MemReady handshake, so variable-latency memory stalls the FSM.
- Supported instructions: LDUR, STUR, ADD, SUB, AND, ORR, CBZ, B.

Parameters:
- CNT_W, 16, width of RetireCount

Ports:
- CLK  input  1  clock, all state updates on rising edge
- Reset  input  1  synchronous, active-high reset
- Opcode  input  11  instruction[31:21] from the instruction register
- MemReady  input  1  memory has completed the current read/write this cycle
- ALUop  output  2  to ALU control: 00 add, 01 pass B (CBZ), 10 R-type funct
- ALUSrcA  output  1  0 = PC, 1 = register A
- ALUSrcB  output  2  00 register B, 01 constant 4, 10 sign-extended D-imm, 11 branch offset << 2
- IorD  output  1  memory address source: 0 = PC, 1 = ALUOut
- MemRead  output  1  memory read request
- MemWrite  output  1  memory write request
- IRWrite  output  1  load instruction register
- PCWrite  output  1  unconditional PC load
- PCWriteCond  output  1  PC load if ALU Zero
- PCSource  output  1  0 = ALU result, 1 = ALUOut
- Reg2Loc  output  1  1 = read register port 2 from Rt field
- MemtoReg  output  1  1 = write-back data from MDR
- RegWrite  output  1  register file write enable
- State  output  4  current state encoding, for debug
- RetireCount  output  CNT_W  count of retired instructions

Behaviour:
- Opcode classes:
  - LDUR = 11111000010
  - STUR = 11111000000
  - ADD = 10001011000, SUB = 11001011000, AND = 10001010000, ORR = 10101010000
  - CBZ: Opcode[10:3] = 10110100
  - B: Opcode[10:5] = 000101
  - Anything else is illegal.
- Reset: on any edge with Reset=1, State becomes FETCH (0) and RetireCount becomes 0. This overrides the current state, including a mid-stall state.
- Outputs: all are Moore outputs decoded from State, except that IRWrite/PCWrite in FETCH are qualified by MemReady. Every output not listed for a state is 0.
- States and transitions:
  - FETCH (0): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUop=00, PCSource=0. IRWrite=PCWrite=MemReady. Go to DECODE if MemReady, else stay.
  - DECODE (1): ALUSrcA=0, ALUSrcB=11, ALUop=00 (branch target into ALUOut), Reg2Loc=1 for STUR/CBZ. Next state: LDUR/STUR → MEMADDR; R-type → EXEC; CBZ → CBZ; B → BRANCH; illegal → FETCH, not retired.
  - MEMADDR (2): ALUSrcA=1, ALUSrcB=10, ALUop=00. Next: MEMRD for LDUR, MEMWR for STUR. Opcode is sampled again here; it must be stable.
  - MEMRD (3): MemRead=1, IorD=1. Stay until MemReady, then go to MEMWB.
  - MEMWB (4): RegWrite=1, MemtoReg=1. Go to FETCH, retire.
  - MEMWR (5): MemWrite=1, IorD=1, Reg2Loc=1. Stay until MemReady, then go to FETCH, retire.
  - EXEC (6): ALUSrcA=1, ALUSrcB=00, ALUop=10. Go to RWB.
  - RWB (7): RegWrite=1, MemtoReg=0. Go to FETCH, retire.
  - CBZ (8): ALUSrcA=1, ALUSrcB=00, ALUop=01, Reg2Loc=1, PCWriteCond=1, PCSource=1. Go to FETCH, retire.
  - BRANCH (9): PCWrite=1, PCSource=1. Go to FETCH, retire.
  - Encodings 10–15: go to FETCH, all outputs 0, no retire.
- Latency in cycles with MemReady=1 immediately: R-type 4, LDUR 5, STUR 4, CBZ 3, B 3. Each cycle MemReady is low adds one cycle in FETCH/MEMRD/MEMWR.
- RetireCount: increments by 1 on the edge leaving a retiring state and wraps modulo 2^CNT_W. If Reset is asserted on that same edge, Reset wins and the count goes to 0.
- MemReady is ignored in every state except FETCH, MEMRD and MEMWR.

Test Plan:
- Reset held 2 cycles, MemReady=1 → State=0, RetireCount=0, MemRead=1, IRWrite=1, PCWrite=1; all other enables 0.
- ADD (10001011000), MemReady=1 → State sequence 0,1,6,7,0; ALUop=10 in state 6; RegWrite=1 only in state 7; RetireCount 0→1.
- LDUR with MemReady low 3 cycles in MEMRD → State sequence 0,1,2,3,3,3,3,4,0; MemRead=1 and IorD=1 throughout state 3; RegWrite=MemtoReg=1 in state 4.
- CBZ (10110100xxx) → State sequence 0,1,8,0; ALUop=01, PCWriteCond=1, Reg2Loc=1 in state 8; then B (000101xxxxx) → 0,1,9,0 with PCWrite=1, PCSource=1.
- Illegal Opcode 11111111111 → State sequence 0,1,0; RetireCount unchanged; no RegWrite/MemWrite asserted.
- Reset asserted while in MEMWR with MemReady=0 → next state 0, RetireCount=0, MemWrite=0; with CNT_W=4 and 16 retirements → RetireCount wraps to 0.

Source files
------------

// File: rtl/legv8_multicycle_control.sv
// Main control FSM for the multicycle LEGv8 datapath: sequences each instruction
// through fetch/decode/execute/memory/writeback and counts retired instructions.
module legv8_multicycle_control #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [10:0]      Opcode,
    input  logic             MemReady,
    output logic [1:0]       ALUop,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             PCSource,
    output logic             Reg2Loc,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic [3:0]       State,
    output logic [CNT_W-1:0] RetireCount
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADDR = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_RWB     = 4'd7,
        S_CBZ     = 4'd8,
        S_BRANCH  = 4'd9
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_retire_cnt;
    logic             w_retire;

    logic w_is_ldur;
    logic w_is_stur;
    logic w_is_rtype;
    logic w_is_cbz;
    logic w_is_b;

    assign w_is_ldur  = (Opcode == 11'b11111000010);
    assign w_is_stur  = (Opcode == 11'b11111000000);
    assign w_is_rtype = (Opcode == 11'b10001011000) || (Opcode == 11'b11001011000) ||
                        (Opcode == 11'b10001010000) || (Opcode == 11'b10101010000);
    assign w_is_cbz   = (Opcode[10:3] == 8'b10110100);
    assign w_is_b     = (Opcode[10:5] == 6'b000101);

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state      <= S_FETCH;
            r_retire_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_retire)
                r_retire_cnt <= r_retire_cnt + 1'b1;
        end
    end

    always_comb begin
        w_state_next = S_FETCH;
        w_retire     = 1'b0;
        ALUop        = 2'b00;
        ALUSrcA      = 1'b0;
        ALUSrcB      = 2'b00;
        IorD         = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        IRWrite      = 1'b0;
        PCWrite      = 1'b0;
        PCWriteCond  = 1'b0;
        PCSource     = 1'b0;
        Reg2Loc      = 1'b0;
        MemtoReg     = 1'b0;
        RegWrite     = 1'b0;
        case (r_state)
            S_FETCH: begin
                MemRead      = 1'b1;
                ALUSrcB      = 2'b01;
                IRWrite      = MemReady;
                PCWrite      = MemReady;
                w_state_next = MemReady ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // Speculatively compute the branch target into ALUOut
                ALUSrcB = 2'b11;
                Reg2Loc = w_is_stur || w_is_cbz;
                if (w_is_ldur || w_is_stur)
                    w_state_next = S_MEMADDR;
                else if (w_is_rtype)
                    w_state_next = S_EXEC;
                else if (w_is_cbz)
                    w_state_next = S_CBZ;
                else if (w_is_b)
                    w_state_next = S_BRANCH;
                else
                    w_state_next = S_FETCH;
            end
            S_MEMADDR: begin
                ALUSrcA      = 1'b1;
                ALUSrcB      = 2'b10;
                w_state_next = w_is_ldur ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                MemRead      = 1'b1;
                IorD         = 1'b1;
                w_state_next = MemReady ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                w_retire = 1'b1;
            end
            S_MEMWR: begin
                MemWrite     = 1'b1;
                IorD         = 1'b1;
                Reg2Loc      = 1'b1;
                w_retire     = MemReady;
                w_state_next = MemReady ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                ALUSrcA      = 1'b1;
                ALUop        = 2'b10;
                w_state_next = S_RWB;
            end
            S_RWB: begin
                RegWrite = 1'b1;
                w_retire = 1'b1;
            end
            S_CBZ: begin
                ALUSrcA     = 1'b1;
                ALUop       = 2'b01;
                Reg2Loc     = 1'b1;
                PCWriteCond = 1'b1;
                PCSource    = 1'b1;
                w_retire    = 1'b1;
            end
            S_BRANCH: begin
                PCWrite  = 1'b1;
                PCSource = 1'b1;
                w_retire = 1'b1;
            end
            default: begin
                w_state_next = S_FETCH;
            end
        endcase
    end

    assign State       = r_state;
    assign RetireCount = r_retire_cnt;

endmodule

// File: tb/tb_legv8_multicycle_control.sv
// Directed bench for legv8_multicycle_control (CNT_W=4 so counter wrap is reachable).
module tb_legv8_multicycle_control;

    localparam int CNT_W = 4;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_CBZ  = 11'b10110100101;
    localparam logic [10:0] OP_B    = 11'b00010110101;
    localparam logic [10:0] OP_ILL  = 11'b11111111111;

    logic             CLK = 1'b0;
    logic             Reset;
    logic [10:0]      Opcode;
    logic             MemReady;
    logic [1:0]       ALUop;
    logic             ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic             IorD;
    logic             MemRead;
    logic             MemWrite;
    logic             IRWrite;
    logic             PCWrite;
    logic             PCWriteCond;
    logic             PCSource;
    logic             Reg2Loc;
    logic             MemtoReg;
    logic             RegWrite;
    logic [3:0]       State;
    logic [CNT_W-1:0] RetireCount;

    int n_checks = 0;
    int n_pass   = 0;

    legv8_multicycle_control #(.CNT_W(CNT_W)) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .Opcode     (Opcode),
        .MemReady   (MemReady),
        .ALUop      (ALUop),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .IorD       (IorD),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .PCWrite    (PCWrite),
        .PCWriteCond(PCWriteCond),
        .PCSource   (PCSource),
        .Reg2Loc    (Reg2Loc),
        .MemtoReg   (MemtoReg),
        .RegWrite   (RegWrite),
        .State      (State),
        .RetireCount(RetireCount)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs === exp_v) begin
            n_pass++;
            $display("check %-22s got %0d ok", tag, obs);
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
        end
    endtask

    // Advance one clock and settle past the edge before sampling
    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        Reset    = 1'b1;
        MemReady = 1'b1;
        Opcode   = OP_ADD;
        tick();
        tick();
        check("rst_state", State, 0);
        check("rst_count", RetireCount, 0);
        check("rst_memread", MemRead, 1);
        check("rst_irwrite", IRWrite, 1);
        check("rst_pcwrite", PCWrite, 1);
        check("rst_alusrcb", ALUSrcB, 1);
        check("rst_others", {RegWrite, MemWrite, PCWriteCond, IorD, Reg2Loc, MemtoReg, ALUSrcA, PCSource}, 0);

        // FETCH stall: IRWrite/PCWrite follow MemReady
        Reset    = 1'b0;
        MemReady = 1'b0;
        #1;
        check("fetch_stall_irwrite", IRWrite, 0);
        tick();
        check("fetch_stall_state", State, 0);
        MemReady = 1'b1;

        // ADD: 0,1,6,7,0
        tick(); check("add_s1", State, 1);
        check("add_s1_alusrcb", ALUSrcB, 3);
        tick(); check("add_s6", State, 6);
        check("add_s6_aluop", ALUop, 2);
        check("add_s6_regwrite", RegWrite, 0);
        tick(); check("add_s7", State, 7);
        check("add_s7_regwrite", RegWrite, 1);
        check("add_s7_count", RetireCount, 0);
        tick(); check("add_s0", State, 0);
        check("add_count", RetireCount, 1);

        // LDUR with three low MemReady cycles in MEMRD
        Opcode = OP_LDUR;
        tick(); check("ldur_s1", State, 1);
        tick(); check("ldur_s2", State, 2);
        check("ldur_s2_alusrcb", ALUSrcB, 2);
        tick(); check("ldur_s3_a", State, 3);
        MemReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ldur_s3_stall", State, 3);
            check("ldur_s3_rd_iord", {MemRead, IorD}, 3);
        end
        MemReady = 1'b1;
        tick(); check("ldur_s4", State, 4);
        check("ldur_s4_wb", {RegWrite, MemtoReg}, 3);
        tick(); check("ldur_s0", State, 0);
        check("ldur_count", RetireCount, 2);

        // CBZ then B
        Opcode = OP_CBZ;
        tick(); check("cbz_s1", State, 1);
        check("cbz_s1_reg2loc", Reg2Loc, 1);
        tick(); check("cbz_s8", State, 8);
        check("cbz_aluop", ALUop, 1);
        check("cbz_pcwcond", PCWriteCond, 1);
        check("cbz_reg2loc", Reg2Loc, 1);
        check("cbz_pcsource", PCSource, 1);
        tick(); check("cbz_s0", State, 0);
        check("cbz_count", RetireCount, 3);
        Opcode = OP_B;
        tick(); check("b_s1", State, 1);
        check("b_s1_reg2loc", Reg2Loc, 0);
        tick(); check("b_s9", State, 9);
        check("b_pcwrite_src", {PCWrite, PCSource}, 3);
        tick(); check("b_s0", State, 0);
        check("b_count", RetireCount, 4);

        // Illegal opcode: 0,1,0, not retired
        Opcode = OP_ILL;
        tick(); check("ill_s1", State, 1);
        check("ill_s1_writes", {RegWrite, MemWrite}, 0);
        tick(); check("ill_s0", State, 0);
        check("ill_count", RetireCount, 4);

        // STUR stalled in MEMWR, then reset mid-stall
        Opcode = OP_STUR;
        tick(); check("stur_s1", State, 1);
        check("stur_s1_reg2loc", Reg2Loc, 1);
        tick(); check("stur_s2", State, 2);
        MemReady = 1'b0;
        tick(); check("stur_s5", State, 5);
        check("stur_s5_ctl", {MemWrite, IorD, Reg2Loc}, 7);
        tick(); check("stur_s5_stall", State, 5);
        check("stur_stall_count", RetireCount, 4);
        Reset = 1'b1;
        tick(); check("rst_mid_state", State, 0);
        check("rst_mid_count", RetireCount, 0);
        check("rst_mid_memwrite", MemWrite, 0);
        Reset    = 1'b0;
        MemReady = 1'b1;

        // 16 B instructions: count wraps modulo 16
        Opcode = OP_B;
        for (int n = 1; n <= 16; n++) begin
            tick(); tick(); tick();
            if (n == 15) check("wrap_count_15", RetireCount, 15);
        end
        check("wrap_state", State, 0);
        check("wrap_count_0", RetireCount, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
